// File: rtl/seven_seg_serial_scanner_if.sv
// Pin bundle of the serial-loaded seven-segment scanner: the serial
// link in, the multiplexed display drive and the status pulses out.
interface seven_seg_serial_scanner_if #(
  parameter int DIGITS = 4
);
  logic              serialClockIn;
  logic              serialDataIn;
  logic [DIGITS-1:0] digitalOutputPins;
  logic [7:0]        segmentOutputPins;
  logic              frameValid;
  logic              frameError;
  logic              serialActivity;

  // Source of the serial link, consumer of the display drive.
  modport master (
    output serialClockIn, serialDataIn,
    input  digitalOutputPins, segmentOutputPins, frameValid, frameError, serialActivity
  );

  // The scanner itself.
  modport slave (
    input  serialClockIn, serialDataIn,
    output digitalOutputPins, segmentOutputPins, frameValid, frameError, serialActivity
  );
endinterface

// File: rtl/seven_seg_serial_scanner.sv
// Multiplexed seven-segment driver whose digit registers are loaded
// over a slow, noisy two-wire serial link (address then segment byte,
// MSB first). Both serial wires are synchronized and debounced; a
// rising edge of the filtered clock shifts one bit in.
module seven_seg_serial_scanner #(
  parameter int DIGITS          = 4,
  parameter int SCAN_CYCLES     = 24000,
  parameter int DEAD_CYCLES     = 240,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int TIMEOUT_CYCLES  = 2400000,
  parameter bit SEG_ACTIVE_LOW  = 1'b0,
  parameter bit DIG_ACTIVE_LOW  = 1'b1
) (
  input logic clock,
  input logic reset,
  seven_seg_serial_scanner_if.slave bus
);

  localparam int ADDR_W    = (DIGITS <= 2) ? 1 : $clog2(DIGITS);
  localparam int FRAME_LEN = ADDR_W + 8;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int DEB_W     = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int IDLE_W    = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int SCAN_W    = (SCAN_CYCLES <= 2) ? 1 : $clog2(SCAN_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [SCAN_W-1:0] DEAD_L    = SCAN_W'(DEAD_CYCLES);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DIGITS - 1);
  localparam logic [ADDR_W:0]   DIGITS_L  = (ADDR_W + 1)'(DIGITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);

  localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} rxState_t;

  // Index 0 = serial clock, index 1 = serial data.
  logic [1:0]            rawIn, syncA, syncB, filt;
  logic [1:0][DEB_W-1:0] debCnt;
  logic                  filtClkDly, clkRise;

  rxState_t              state, stateNext;
  logic [CNT_W-1:0]      bitCnt, cntNext;
  logic [FRAME_LEN-1:0]  shiftReg, shiftNext;
  logic [IDLE_W-1:0]     idleCnt, idleNext;
  logic                  writeEn, errPulse;
  logic [ADDR_W-1:0]     frameAddr;
  logic [7:0]            frameByte;
  logic                  addrOk;

  logic [DIGITS-1:0][7:0] digitRegs;
  logic [SCAN_W-1:0]      scanCnt;
  logic [ADDR_W-1:0]      digitIdx;
  logic [DIGITS-1:0]      activeOneHot;
  logic [DIGITS-1:0]      digitSel;
  logic [7:0]             segOut;
  logic                   validQ, errorQ;

  assign rawIn = {bus.serialDataIn, bus.serialClockIn};

  // Two-flop synchronizers for both asynchronous serial wires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= rawIn;
      syncB <= syncA;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt   <= '0;
      debCnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (syncB[i] == filt[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEB_LAST) begin
          filt[i]   <= syncB[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed filtered clock for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) filtClkDly <= 1'b0;
    else       filtClkDly <= filt[0];
  end

  assign clkRise   = filt[0] & ~filtClkDly;
  assign frameAddr = shiftReg[FRAME_LEN-1 -: ADDR_W];
  assign frameByte = shiftReg[7:0];
  assign addrOk    = {1'b0, frameAddr} < DIGITS_L;

  // Receiver state, bit counter, shift register and idle timer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      shiftReg <= '0;
      idleCnt  <= '0;
    end else begin
      state    <= stateNext;
      bitCnt   <= cntNext;
      shiftReg <= shiftNext;
      idleCnt  <= idleNext;
    end
  end

  // Receiver next state: shift on filtered edges, commit one cycle after
  // the last bit, abort a stalled partial frame. An edge during COMMIT
  // already belongs to the next frame.
  always_comb begin
    stateNext = state;
    cntNext   = bitCnt;
    shiftNext = shiftReg;
    idleNext  = idleCnt;
    writeEn   = 1'b0;
    errPulse  = 1'b0;
    case (state)
      IDLE: begin
        if (clkRise) begin
          shiftNext = {shiftReg[FRAME_LEN-2:0], filt[1]};
          cntNext   = CNT_W'(1);
          idleNext  = '0;
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (clkRise) begin
          shiftNext = {shiftReg[FRAME_LEN-2:0], filt[1]};
          cntNext   = bitCnt + 1'b1;
          idleNext  = '0;
          if (bitCnt == LAST_BIT) stateNext = COMMIT;
        end else if (idleCnt == IDLE_LAST) begin
          cntNext   = '0;
          idleNext  = '0;
          errPulse  = 1'b1;
          stateNext = IDLE;
        end else begin
          idleNext = idleCnt + 1'b1;
        end
      end
      COMMIT: begin
        if (addrOk) writeEn  = 1'b1;
        else        errPulse = 1'b1;
        cntNext   = '0;
        idleNext  = '0;
        stateNext = IDLE;
        if (clkRise) begin
          shiftNext = {shiftReg[FRAME_LEN-2:0], filt[1]};
          cntNext   = CNT_W'(1);
          stateNext = SHIFT;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Digit registers and the registered status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digitRegs <= '0;
      validQ    <= 1'b0;
      errorQ    <= 1'b0;
    end else begin
      validQ <= writeEn;
      errorQ <= errPulse;
      for (int i = 0; i < DIGITS; i++) begin
        if (writeEn && frameAddr == ADDR_W'(i)) digitRegs[i] <= frameByte;
      end
    end
  end

  assign activeOneHot = DIGITS'(1) << digitIdx;

  // Scan timing plus registered digit/segment drive; the start of each
  // slot is blanked so the previous digit's pattern never ghosts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scanCnt  <= '0;
      digitIdx <= '0;
      digitSel <= DIG_OFF;
      segOut   <= SEG_OFF;
    end else begin
      if (scanCnt == SCAN_LAST) begin
        scanCnt  <= '0;
        digitIdx <= (digitIdx == IDX_LAST) ? '0 : digitIdx + 1'b1;
      end else begin
        scanCnt <= scanCnt + 1'b1;
      end
      if (scanCnt < DEAD_L) begin
        digitSel <= DIG_OFF;
        segOut   <= SEG_OFF;
      end else begin
        digitSel <= DIG_ACTIVE_LOW ? ~activeOneHot : activeOneHot;
        segOut   <= digitRegs[digitIdx] ^ SEG_OFF;
      end
    end
  end

  assign bus.digitalOutputPins = digitSel;
  assign bus.segmentOutputPins = segOut;
  assign bus.frameValid        = validQ;
  assign bus.frameError        = errorQ;
  assign bus.serialActivity    = filt[0];

endmodule
